// File: rtl/pio_wmem_bram_nw_pkg.sv
// Shared constants and word classification for the PIO wide memory.
// An entry spans NWORDS PIO dwords; the last dword commits the entry.
package pio_wmem_bram_nw_pkg;
  localparam int PIO_NBITS = 32;
  localparam int MAX_WORDS = 8;

  typedef enum logic [1:0] {
    WK_FIRST,
    WK_MID,
    WK_LAST,
    WK_OUT
  } wkind_e;

  function automatic int nwords(input int width);
    return (width + PIO_NBITS - 1) / PIO_NBITS;
  endfunction

  function automatic wkind_e word_kind(input int w, input int nw);
    if (w == 0) return WK_FIRST;
    if (w < nw - 1) return WK_MID;
    if (w == nw - 1) return WK_LAST;
    return WK_OUT;
  endfunction
endpackage

// File: rtl/pio_wmem_bram_nw_stage.sv
// PIO write staging and read shadow for one wide entry.
// Shadow is zero-extended so the top word reads 0 above WIDTH.
module pio_wmem_stage
  import pio_wmem_bram_nw_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int NWORDS     = 4,
  parameter int WORD_NBITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stage_wr_i,
  input  logic [WORD_NBITS-1:0] w_i,
  input  logic [PIO_NBITS-1:0]  din_i,
  output logic [WIDTH-1:0]      commit_o,
  input  logic                  shadow_ld_i,
  input  logic [WIDTH-1:0]      shadow_i,
  output logic [PIO_NBITS-1:0]  rword_o
);
  localparam int PADW = NWORDS * PIO_NBITS;

  logic [NWORDS-2:0][PIO_NBITS-1:0] wstage_q;
  logic [NWORDS-1:0][PIO_NBITS-1:0] rshadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstage_q  <= '0;
      rshadow_q <= '0;
    end else begin
      for (int i = 0; i < NWORDS - 1; i++)
        if (stage_wr_i && int'(w_i) == i) wstage_q[i] <= din_i;
      if (shadow_ld_i) rshadow_q <= PADW'(shadow_i);
    end
  end

  assign commit_o = WIDTH'({din_i, wstage_q});

  always_comb begin
    rword_o = '0;
    for (int i = 0; i < NWORDS; i++)
      if (int'(w_i) == i) rword_o = rshadow_q[i];
  end
endmodule

// File: rtl/ram_1r1w_bram.sv
// Simple dual-port block RAM, one write and one registered read port.
// Read-first: a same-cycle read of the written address returns old data.
module ram_1r1w_bram #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   wr_i,
  input  logic [DEPTH_NBITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [DEPTH_NBITS-1:0] raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_NBITS];

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/pio_wmem_bram_nw.sv
// PIO-accessible wide memory with an application read/write port.
// App accesses win the RAM ports; PIO commits and reads are deferred.
module pio_wmem_bram_nw
  import pio_wmem_bram_nw_pkg::*;
#(
  parameter int WIDTH       = 100,
  parameter int DEPTH_NBITS = 10,
  parameter int WORD_NBITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_div,
  input  logic [PIO_NBITS-1:0]   reg_addr,
  input  logic [PIO_NBITS-1:0]   reg_din,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic                   reg_ms,
  input  logic                   app_mem_rd,
  input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
  input  logic                   app_mem_wr,
  input  logic [DEPTH_NBITS-1:0] app_mem_waddr,
  input  logic [WIDTH-1:0]       app_mem_wdata,
  output logic                   mem_ack,
  output logic [PIO_NBITS-1:0]   mem_rdata,
  output logic                   app_mem_ack,
  output logic [WIDTH-1:0]       app_mem_rdata
);
  localparam int NWORDS = nwords(WIDTH);
  localparam int AHI    = DEPTH_NBITS + WORD_NBITS + 1;

  if (NWORDS > 2 ** WORD_NBITS) begin : g_chk_words
    $error("NWORDS exceeds the PIO dword stride");
  end
  if (WIDTH < 33 || WIDTH > MAX_WORDS * PIO_NBITS) begin : g_chk_width
    $error("WIDTH out of range");
  end

  logic [WORD_NBITS-1:0]  w;
  logic [DEPTH_NBITS-1:0] ent;
  wkind_e                 kind;
  logic                   pio_wr, pio_rd, stage_wr, commit, rd_first;
  logic                   unused_addr;
  logic [WIDTH-1:0]       commit_data;
  logic [PIO_NBITS-1:0]   shadow_word;

  assign w           = reg_addr[WORD_NBITS+1:2];
  assign ent         = reg_addr[AHI:WORD_NBITS+2];
  assign unused_addr = ^{reg_addr[PIO_NBITS-1:AHI+1], reg_addr[1:0]};
  assign kind        = word_kind(int'(w), NWORDS);
  assign pio_wr      = reg_ms & reg_wr;
  assign pio_rd      = reg_ms & reg_rd & ~reg_wr;
  assign stage_wr    = pio_wr & ((kind == WK_FIRST) | (kind == WK_MID));
  assign commit      = pio_wr & (kind == WK_LAST);
  assign rd_first    = pio_rd & (kind == WK_FIRST);

  logic                   cpend_q, cpend_d;
  logic [DEPTH_NBITS-1:0] cpend_addr_q;
  logic [WIDTH-1:0]       cpend_data_q;
  logic                   prd_q, prd_d;
  logic [DEPTH_NBITS-1:0] prd_addr_q;
  logic                   rd1_q, rd2_q, pdv_q;
  logic [DEPTH_NBITS-1:0] raddr_q;
  logic                   req_q, req_d;
  logic                   ram_we, pio_iss;
  logic [DEPTH_NBITS-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]       ram_wdata, ram_rdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = app_mem_waddr;
    ram_wdata = app_mem_wdata;
    if (app_mem_wr) begin
      ram_we = 1'b1;
    end else if (cpend_q) begin
      ram_we    = 1'b1;
      ram_waddr = cpend_addr_q;
      ram_wdata = cpend_data_q;
    end else if (commit) begin
      ram_we    = 1'b1;
      ram_waddr = ent;
      ram_wdata = commit_data;
    end
    ram_we = ram_we & ~rst;
  end

  // A commit pends while the write port is taken, so PIO data lands last.
  assign cpend_d   = (commit & (app_mem_wr | cpend_q))
                   | (cpend_q & app_mem_wr);
  assign pio_iss   = prd_q & ~rd1_q;
  assign ram_raddr = rd1_q ? raddr_q : prd_addr_q;
  assign prd_d     = rd_first | (prd_q & rd1_q);
  assign req_d     = pdv_q | pio_wr | (pio_rd & ~rd_first)
                   | (req_q & ~clk_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      cpend_q       <= 1'b0;
      cpend_addr_q  <= '0;
      cpend_data_q  <= '0;
      prd_q         <= 1'b0;
      prd_addr_q    <= '0;
      rd1_q         <= 1'b0;
      rd2_q         <= 1'b0;
      pdv_q         <= 1'b0;
      raddr_q       <= '0;
      req_q         <= 1'b0;
      mem_ack       <= 1'b0;
      mem_rdata     <= '0;
      app_mem_ack   <= 1'b0;
      app_mem_rdata <= '0;
    end else begin
      cpend_q <= cpend_d;
      if (commit) begin
        cpend_addr_q <= ent;
        cpend_data_q <= commit_data;
      end
      prd_q <= prd_d;
      if (rd_first) prd_addr_q <= ent;
      rd1_q   <= app_mem_rd;
      raddr_q <= app_mem_raddr;
      rd2_q   <= rd1_q;
      pdv_q   <= pio_iss;
      req_q   <= req_d;
      if (clk_div) mem_ack <= req_q;
      app_mem_ack <= rd2_q;
      if (rd2_q) app_mem_rdata <= ram_rdata;
      if (pdv_q) mem_rdata <= ram_rdata[PIO_NBITS-1:0];
      else if (pio_rd & ~rd_first) mem_rdata <= shadow_word;
    end
  end

  pio_wmem_stage #(
    .WIDTH     (WIDTH),
    .NWORDS    (NWORDS),
    .WORD_NBITS(WORD_NBITS)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .stage_wr_i (stage_wr),
    .w_i        (w),
    .din_i      (reg_din),
    .commit_o   (commit_data),
    .shadow_ld_i(pdv_q),
    .shadow_i   (ram_rdata),
    .rword_o    (shadow_word)
  );

  ram_1r1w_bram #(
    .WIDTH      (WIDTH),
    .DEPTH_NBITS(DEPTH_NBITS)
  ) u_ram (
    .clk    (clk),
    .wr_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );
endmodule

// File: tb/tb_pio_wmem_bram_nw.sv
// Directed bench for pio_wmem_bram_nw (WIDTH=100, 8-dword stride).
// Expected values are hand-computed constants.
module tb_pio_wmem_bram_nw;
  localparam int W  = 100;
  localparam int DN = 10;
  localparam int WN = 3;

  localparam logic [W-1:0] E5 = 100'h4_33333333_22222222_11111111;
  localparam logic [W-1:0] P7 = 100'h9_87654321_0FEDCBA9_13579BDF;
  localparam logic [W-1:0] E3 = 100'h5_12345678_0000BBBB_AAAA0000;
  localparam logic [W-1:0] P9 = 100'hC_DEADBEEF_CAFEF00D_01234567;
  localparam logic [W-1:0] Q  = 100'h3_00000000_FFFFFFFF_00000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_div;
  logic [31:0]   reg_addr, reg_din;
  logic          reg_rd, reg_wr, reg_ms;
  logic          app_mem_rd, app_mem_wr;
  logic [DN-1:0] app_mem_raddr, app_mem_waddr;
  logic [W-1:0]  app_mem_wdata;
  logic          mem_ack, app_mem_ack;
  logic [31:0]   mem_rdata;
  logic [W-1:0]  app_mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int div_cnt = 0;
  bit div_mode = 1'b0;

  pio_wmem_bram_nw #(
    .WIDTH(W), .DEPTH_NBITS(DN), .WORD_NBITS(WN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_div      (clk_div),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .reg_rd       (reg_rd),
    .reg_wr       (reg_wr),
    .reg_ms       (reg_ms),
    .app_mem_rd   (app_mem_rd),
    .app_mem_raddr(app_mem_raddr),
    .app_mem_wr   (app_mem_wr),
    .app_mem_waddr(app_mem_waddr),
    .app_mem_wdata(app_mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .app_mem_ack  (app_mem_ack),
    .app_mem_rdata(app_mem_rdata)
  );

  always #5 clk = ~clk;

  // clk_div changes 2ns after the edge, so at edge+1 it shows the sampled value.
  initial begin
    clk_div = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      div_cnt = div_cnt + 1;
      clk_div = !div_mode || (div_cnt % 4 == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pa(input int e, input int wd);
    return 32'((e << (WN + 2)) + (wd << 2));
  endfunction

  task automatic app_wr(input int a, input logic [W-1:0] d);
    app_mem_wr    = 1'b1;
    app_mem_waddr = DN'(a);
    app_mem_wdata = d;
    tick;
    app_mem_wr = 1'b0;
  endtask

  task automatic app_rd(input string tag, input int a,
                        input logic [W-1:0] exp);
    app_mem_rd    = 1'b1;
    app_mem_raddr = DN'(a);
    tick;
    app_mem_rd = 1'b0;
    tick;
    chk({tag, "_early"}, 128'(app_mem_ack), 128'd0);
    tick;
    chk({tag, "_ack"}, 128'(app_mem_ack), 128'd1);
    chk({tag, "_data"}, 128'(app_mem_rdata), 128'(exp));
  endtask

  task automatic pio_op(input string tag, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q);
    int   rises;
    logic prev;
    rises = 0;
    prev  = mem_ack;
    q     = 'x;
    reg_ms   = 1'b1;
    reg_wr   = wr;
    reg_rd   = !wr;
    reg_addr = a;
    reg_din  = d;
    tick;
    reg_ms = 1'b0;
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mem_ack && !prev) begin
        rises++;
        chk({tag, "_ackdiv"}, 128'(clk_div), 128'd1);
        if (rises == 1) q = mem_rdata;
      end
      prev = mem_ack;
      tick;
    end
    chk({tag, "_ackcnt"}, 128'(rises), 128'd1);
  endtask

  initial begin
    logic [31:0] q;
    int          first_ack;
    logic        exp_ack;

    rst = 1'b1;
    reg_addr = '0; reg_din = '0;
    reg_rd = 1'b0; reg_wr = 1'b0; reg_ms = 1'b0;
    app_mem_rd = 1'b0; app_mem_wr = 1'b0;
    app_mem_raddr = '0; app_mem_waddr = '0; app_mem_wdata = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_mem_ack", 128'(mem_ack), 128'd0);
    chk("rst_app_ack", 128'(app_mem_ack), 128'd0);
    chk("rst_mem_rdata", 128'(mem_rdata), 128'd0);
    chk("rst_app_rdata", 128'(app_mem_rdata), 128'd0);

    pio_op("w5_0", 1'b1, pa(5, 0), 32'h11111111, q);
    pio_op("w5_1", 1'b1, pa(5, 1), 32'h22222222, q);
    pio_op("w5_2", 1'b1, pa(5, 2), 32'h33333333, q);
    pio_op("w5_3", 1'b1, pa(5, 3), 32'hF4444444, q);
    app_rd("a5", 5, E5);
    pio_op("r5_0", 1'b0, pa(5, 0), 32'h0, q);
    chk("r5_0_data", 128'(q), 128'h11111111);
    pio_op("r5_3", 1'b0, pa(5, 3), 32'h0, q);
    chk("r5_3_data", 128'(q), 128'h00000004);
    pio_op("r5_1", 1'b0, pa(5, 1), 32'h0, q);
    chk("r5_1_data", 128'(q), 128'h22222222);

    app_wr(7, P7);
    pio_op("w7_0", 1'b1, pa(7, 0), 32'hAAAAAAAA, q);
    pio_op("w7_1", 1'b1, pa(7, 1), 32'hBBBBBBBB, q);
    pio_op("w7_2", 1'b1, pa(7, 2), 32'hCCCCCCCC, q);
    pio_op("w7_5", 1'b1, pa(7, 5), 32'hDDDDDDDD, q);
    app_rd("a7", 7, P7);

    pio_op("w3_0", 1'b1, pa(3, 0), 32'hAAAA0000, q);
    pio_op("w3_1", 1'b1, pa(3, 1), 32'h0000BBBB, q);
    pio_op("w3_2", 1'b1, pa(3, 2), 32'h12345678, q);
    reg_ms = 1'b1; reg_wr = 1'b1;
    reg_addr = pa(3, 3); reg_din = 32'hFFFFFFF5;
    app_mem_wr = 1'b1; app_mem_waddr = DN'(3); app_mem_wdata = '1;
    tick;
    reg_ms = 1'b0; reg_wr = 1'b0; app_mem_wr = 1'b0;
    tick;
    chk("coll_mem_ack", 128'(mem_ack), 128'd1);
    app_rd("a3", 3, E3);

    app_wr(9, P9);
    first_ack = 0;
    for (int k = 0; k < 16; k++) begin
      app_mem_rd    = (k < 6);
      app_mem_raddr = DN'(5);
      reg_ms   = (k == 1);
      reg_rd   = (k == 1);
      reg_addr = pa(9, 0);
      tick;
      exp_ack = (k + 1 >= 3) && (k + 1 <= 8);
      chk("busy_appack", 128'(app_mem_ack), 128'(exp_ack));
      if (exp_ack) chk("busy_appdat", 128'(app_mem_rdata), 128'(E5));
      if (mem_ack && first_ack == 0) begin
        first_ack = k + 1;
        chk("busy_rdata", 128'(mem_rdata), 128'h01234567);
      end
    end
    app_mem_rd = 1'b0; reg_ms = 1'b0; reg_rd = 1'b0;
    chk("busy_ack_after_free", 128'(first_ack >= 8), 128'd1);

    div_mode = 1'b1;
    pio_op("r9_4", 1'b0, pa(9, 4), 32'h0, q);
    chk("r9_4_data", 128'(q), 128'h0);
    pio_op("r9_7", 1'b0, pa(9, 7), 32'h0, q);
    chk("r9_7_data", 128'(q), 128'h0);
    pio_op("w9_6", 1'b1, pa(9, 6), 32'h77777777, q);
    pio_op("r9_2", 1'b0, pa(9, 2), 32'h0, q);
    chk("r9_2_data", 128'(q), 128'hDEADBEEF);
    pio_op("r9_3", 1'b0, pa(9, 3), 32'h0, q);
    chk("r9_3_data", 128'(q), 128'h0000000C);
    div_mode = 1'b0;
    tick;
    tick;
    app_rd("a9", 9, P9);

    pio_op("w11_0", 1'b1, pa(11, 0), 32'h5, q);
    pio_op("w11_1", 1'b1, pa(11, 1), 32'h6, q);
    pio_op("w11_2", 1'b1, pa(11, 2), 32'h7, q);
    reg_ms = 1'b1; reg_wr = 1'b1;
    reg_addr = pa(11, 3); reg_din = 32'h8;
    app_mem_wr = 1'b1; app_mem_waddr = DN'(11); app_mem_wdata = Q;
    tick;
    reg_ms = 1'b0; reg_wr = 1'b0; app_mem_wr = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_mem_ack", 128'(mem_ack), 128'd0);
    chk("rst2_app_ack", 128'(app_mem_ack), 128'd0);
    chk("rst2_mem_rdata", 128'(mem_rdata), 128'd0);
    chk("rst2_app_rdata", 128'(app_mem_rdata), 128'd0);
    app_rd("a11", 11, Q);
    pio_op("r11_1", 1'b0, pa(11, 1), 32'h0, q);
    chk("r11_1_data", 128'(q), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_wmem_bram_nw.md
Name: pio_wmem_bram_nw

Overview:
- PIO-accessible wide memory; successor to the two-word PIO wide memory.
- Entries are WIDTH bits, with any WIDTH up to 32*MAX_WORDS, split into NWORDS = ceil(WIDTH/32) PIO dwords.
- Adds an application write port, deferred PIO commit on collision, and a zero-fill partial top word.
- Sits beside datapath lookup engines: software loads and inspects tables over PIO while the engine reads and updates them at line rate.

Parameters:
WIDTH, 100, entry width in bits (33..256)
DEPTH_NBITS, 10, log2 of entry count
WORD_NBITS, 2, log2 of the PIO dword stride per entry; NWORDS must be <= 2**WORD_NBITS (elaboration error otherwise)

Ports:
clk  in  1  core clock
rst  in  1  reset (`RESET_SIG)
clk_div  in  1  PIO clock-enable strobe
reg_addr  in  `PIO_RANGE  PIO byte address; [WORD_NBITS+1:2] = dword index w, [DEPTH_NBITS+WORD_NBITS+1:WORD_NBITS+2] = entry index
reg_din  in  `PIO_RANGE  PIO write data
reg_rd  in  1  PIO read strobe
reg_wr  in  1  PIO write strobe
reg_ms  in  1  PIO module select
app_mem_rd  in  1  app read request
app_mem_raddr  in  DEPTH_NBITS  app read address
app_mem_wr  in  1  app write request
app_mem_waddr  in  DEPTH_NBITS  app write address
app_mem_wdata  in  WIDTH  app write data
mem_ack  out  1  PIO access done
mem_rdata  out  `PIO_RANGE  PIO read data
app_mem_ack  out  1  app read data valid
app_mem_rdata  out  WIDTH  app read data

Behaviour:
- Reset: synchronous, active-high, one clock. Outputs mem_ack=0, app_mem_ack=0, mem_rdata=0, app_mem_rdata=0. Staging/shadow registers 0; pending flags 0.
- Storage: ram_1r1w_bram #(WIDTH,DEPTH_NBITS), read-first. A read of an address being written in the same cycle returns old data.
- PIO write, w < NWORDS-1: captures reg_din into wstage[w]; RAM not touched.
- PIO write, w = NWORDS-1: commits {reg_din, wstage[NWORDS-2:0]} truncated to WIDTH to the entry.
  - If app_mem_wr is asserted the same cycle, the app write wins and the PIO commit is held in a pending register and written the next cycle. PIO data is last.
- PIO write, w >= NWORDS: ignored; acked.
- PIO read, w = 0: reads the RAM entry, latches all words into rshadow, returns word 0.
  - If an app read occupies the RAM read port that cycle, the PIO read is saved as pending and issued on the first cycle with no app read.
  - App reads always have priority.
- PIO read, 0 < w < NWORDS: returns rshadow[w] with no RAM access. Bits above WIDTH in the top word read as 0.
- PIO read, w >= NWORDS: returns 0.
- mem_ack: each completed PIO access sets an internal request.
  - mem_ack <= clk_div ? req : mem_ack.
  - req clears on the clk_div cycle that transfers it.
  - Pending PIO read: mem_ack stays 0 until the deferred read data is in mem_rdata.
- App read: app_mem_rd at T; RAM address issued at T+1; app_mem_ack=1 and app_mem_rdata valid at T+3 for one cycle. Fully pipelined; one request per cycle; no backpressure.
- App write: written at T+0, visible to a RAM read issued at T+1 or later.
- Reset mid-operation: pending commit and pending read are discarded; no RAM write occurs after rst.

Decomposition:
- Shared defines (defines.vh): `PIO_RANGE, `PIO_NBITS, `RESET_SIG.
- Local constant: NWORDS.
- One sub-module, pio_wmem_stage: write staging array, read shadow array, word select, and top-word zero mask.
- RAM instance and arbitration stay in the top level.

Test Plan:
- WIDTH=100, PIO-write dwords 0..3 of entry 5 with 0x11111111, 0x22222222, 0x33333333, 0xF4444444 -> app read of 5 gives 100'h4_33333333_22222222_11111111. PIO read dword 3 returns 0x00000004.
- Write dwords 0..2 only of entry 7 -> entry 7 unchanged (still reset/init data).
- PIO commit to entry 3 in the same cycle as app write 3 = all-ones -> final entry 3 equals the PIO data; app read at T+2 sees the PIO data.
- PIO read dword 0 of entry 9 during continuous app reads for 6 cycles -> mem_ack is held until the 1st free cycle; mem_rdata = entry9[31:0]. App acks arrive every cycle at T+3 unaffected.
- clk_div high one cycle in four -> mem_ack rises only on a clk_div cycle, one ack per PIO access; dword-4 read returns 0.
- rst asserted one cycle after a deferred commit -> entry not written; all outputs 0 the cycle after rst.
